// File: rtl/led_frame_loader.sv
// Byte-stream frame loader for a 16x8 1-bit LED panel with a zero-latency read port.
// Define LED_LOADER_DBUF_EN for frame-synchronous double buffering; default is a single buffer.
module led_frame_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       frame_sync,
  input  logic [3:0] rd_col,
  input  logic [2:0] rd_row,
  output logic       rd_pixel,
  output logic       front_sel,
  output logic       cmd_err,
  output logic [1:0] dbg_state
);

  // Handshake: a byte transfers on a rising clk edge where in_valid & in_ready are both high;
  // in_ready depends only on the current state, never on in_valid.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLDATA  = 2'd1,
    S_CLEAR    = 2'd2,
    S_SWAPWAIT = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_col;
  logic [3:0] r_ccnt;
  logic       r_cmd_err;

  logic [3:0] w_opcode;
  logic       w_latch_col;
  logic       w_set_err;
  logic       w_wr_en;
  logic [3:0] w_wr_col;
  logic [7:0] w_wr_data;

  assign w_opcode  = in_data[7:4];
  assign cmd_err   = r_cmd_err;
  assign dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_latch_col = 1'b0;
    w_set_err   = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_col    = r_col;
    w_wr_data   = in_data;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (w_opcode)
            4'h0: begin
            end
            4'h1: begin
              w_state_nxt = S_COLDATA;
              w_latch_col = 1'b1;
            end
            4'h2: w_state_nxt = S_CLEAR;
            4'h3: begin
`ifdef LED_LOADER_DBUF_EN
              w_state_nxt = S_SWAPWAIT;
`endif
            end
            default: w_set_err = 1'b1;
          endcase
        end
      end
      S_COLDATA: begin
        // The data byte is stored verbatim, never decoded as an opcode.
        in_ready = 1'b1;
        if (in_valid) begin
          w_wr_en     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_wr_en   = 1'b1;
        w_wr_col  = r_ccnt;
        w_wr_data = 8'h00;
        if (r_ccnt == 4'd15) w_state_nxt = S_IDLE;
      end
      S_SWAPWAIT: begin
        if (frame_sync) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col     <= 4'd0;
      r_ccnt    <= 4'd0;
      r_cmd_err <= 1'b0;
    end else begin
      if (w_latch_col) r_col <= in_data[3:0];
      // Counter sits at 0 outside CLEAR, so each clear starts from column 0.
      if (r_state == S_CLEAR) r_ccnt <= r_ccnt + 4'd1;
      else                    r_ccnt <= 4'd0;
      if (w_set_err) r_cmd_err <= 1'b1;
    end
  end

`ifdef LED_LOADER_DBUF_EN
  logic [15:0][7:0] r_buf0;
  logic [15:0][7:0] r_buf1;
  logic             r_front_sel;

  // Writes always target the buffer not on display; a flip only happens in SWAPWAIT,
  // so it never coincides with a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_front_sel <= 1'b0;
    end else begin
      if ((r_state == S_SWAPWAIT) && frame_sync) r_front_sel <= ~r_front_sel;
      if (w_wr_en) begin
        if (r_front_sel) r_buf0[w_wr_col] <= w_wr_data;
        else             r_buf1[w_wr_col] <= w_wr_data;
      end
    end
  end

  assign front_sel = r_front_sel;
  assign rd_pixel  = r_front_sel ? r_buf1[rd_col][rd_row] : r_buf0[rd_col][rd_row];
`else
  logic [15:0][7:0] r_buf;

  always_ff @(posedge clk) begin
    if (reset)        r_buf           <= '0;
    else if (w_wr_en) r_buf[w_wr_col] <= w_wr_data;
  end

  assign front_sel = 1'b0;
  assign rd_pixel  = r_buf[rd_col][rd_row];
`endif

endmodule
